tick_period_meter: RTL and testbench

Receive side of the tick-generation scheme: measures the spacing between incoming single-cycle ticks, for example the max_tick of a mod-M counter or a line/frame strobe. It counts clk_en-qualified cycles between consecutive ticks and reports the measured period with a one-cycle valid pulse. It flags lock when consecutive periods match and flags overflow when no tick arrives within the counter range. It is used by the tracker to verify pixel, line and frame timing and to derive timing from external strobes.

---
 rtl/tracker_timing_pkg.sv | 15 +
 rtl/period_counter.sv | 38 +++
 rtl/tick_period_meter.sv | 125 ++++++++++++
 tb/tb_tick_period_meter.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/tracker_timing_pkg.sv
// Shared timing-tracker definitions: meter FSM encoding and lock-match counter width.
package tracker_timing_pkg;

  localparam logic StateSync    = 1'b0;
  localparam logic StateMeasure = 1'b1;

  typedef enum logic {
    StSync    = StateSync,
    StMeasure = StateMeasure
  } meter_state_e;

  // Wide enough for LOCK_COUNT-1 with LOCK_COUNT up to 15.
  localparam int unsigned MatchCntW = 4;

endpackage

// File: rtl/period_counter.sv
// Loadable N-bit qualified-cycle counter that saturates instead of wrapping.
module period_counter #(
  parameter int unsigned N = 16
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         clk_en_i,
  input  logic         load_i,
  input  logic         inc_i,
  output logic [N-1:0] cnt_o,
  output logic         sat_o
);

  logic [N-1:0] cnt_q, cnt_d;

  assign sat_o = &cnt_q;
  assign cnt_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clk_en_i) begin
      if (load_i) begin
        cnt_d = {{(N-1){1'b0}}, 1'b1};
      end else if (inc_i && !sat_o) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tick_period_meter.sv
// Measures qualified-cycle spacing between ticks; reports period, lock and sticky overflow.
module tick_period_meter
  import tracker_timing_pkg::*;
#(
  parameter int unsigned N          = 16,
  parameter int unsigned LOCK_COUNT = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clk_en,
  input  logic         tick_in,
  input  logic         clear,
  output logic [N-1:0] period,
  output logic         period_valid,
  output logic         locked,
  output logic         overflow
);

  localparam logic [MatchCntW-1:0] LockMax = MatchCntW'(LOCK_COUNT - 1);

  meter_state_e         state_q, state_d;
  logic [N-1:0]         period_q, period_d;
  logic                 valid_q, valid_d;
  logic                 locked_q, locked_d;
  logic                 ovf_q, ovf_d;
  logic                 first_q, first_d;
  logic [MatchCntW-1:0] match_q, match_d;

  logic         cnt_load, cnt_inc, cnt_zero, cnt_sat;
  logic [N-1:0] cnt;

  // Counter is zeroed by reset, soft clear, and on the overflow return to SYNC.
  period_counter #(
    .N (N)
  ) u_period_counter (
    .clk_i    (clk),
    .reset_i  (reset | clear | cnt_zero),
    .clk_en_i (clk_en),
    .load_i   (cnt_load),
    .inc_i    (cnt_inc),
    .cnt_o    (cnt),
    .sat_o    (cnt_sat)
  );

  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    valid_d  = 1'b0;
    locked_d = locked_q;
    ovf_d    = ovf_q;
    first_d  = first_q;
    match_d  = match_q;
    cnt_load = 1'b0;
    cnt_inc  = 1'b0;
    cnt_zero = 1'b0;
    if (clk_en) begin
      unique case (state_q)
        StSync: begin
          if (tick_in) begin
            cnt_load = 1'b1;
            state_d  = StMeasure;
          end
        end
        StMeasure: begin
          if (tick_in) begin
            period_d = cnt;
            valid_d  = 1'b1;
            cnt_load = 1'b1;
            first_d  = 1'b1;
            if (first_q && (cnt == period_q)) begin
              match_d = (match_q >= LockMax) ? LockMax : match_q + 1'b1;
              if (match_d == LockMax) locked_d = 1'b1;
            end else begin
              match_d  = '0;
              locked_d = 1'b0;
            end
          end else if (cnt_sat) begin
            ovf_d    = 1'b1;
            locked_d = 1'b0;
            match_d  = '0;
            first_d  = 1'b0;
            cnt_zero = 1'b1;
            state_d  = StSync;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        default: state_d = StSync;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StSync;
      period_q <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      ovf_q    <= 1'b0;
      first_q  <= 1'b0;
      match_q  <= '0;
    end else if (clear) begin
      state_q  <= StSync;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      ovf_q    <= 1'b0;
      first_q  <= 1'b0;
      match_q  <= '0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
      ovf_q    <= ovf_d;
      first_q  <= first_d;
      match_q  <= match_d;
    end
  end

  assign period       = period_q;
  assign period_valid = valid_q;
  assign locked       = locked_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_tick_period_meter.sv
// Scoreboard bench for tick_period_meter (N=4, LOCK_COUNT=2) with directed tick spacings.
module tb_tick_period_meter;

  localparam int unsigned N = 4;

  logic         clk = 1'b0;
  logic         reset, clk_en, tick_in, clear;
  logic [N-1:0] period;
  logic         period_valid, locked, overflow;

  typedef struct packed {
    logic [N-1:0] p;
    logic         lk;
    logic         ov;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic en_prev = 1'b0;

  tick_period_meter #(
    .N          (N),
    .LOCK_COUNT (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .clk_en       (clk_en),
    .tick_in      (tick_in),
    .clear        (clear),
    .period       (period),
    .period_valid (period_valid),
    .locked       (locked),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic en, input logic tk);
    clk_en  = en;
    tick_in = tk;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int p, input logic lk, input logic ov);
    exp_t e;
    e.p  = p[N-1:0];
    e.lk = lk;
    e.ov = ov;
    sb.push_back(e);
  endtask

  // m-1 idle qualified cycles then a tick: spacing of m qualified cycles.
  task automatic gap_tick(input int m);
    for (int i = 0; i < m - 1; i++) cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
  endtask

  // Same spacing, but every qualified cycle is preceded by a disabled one with tick high.
  task automatic gap_tick_alt(input int m);
    for (int i = 0; i < m; i++) begin
      cyc(1'b0, 1'b1);
      cyc(1'b1, (i == m - 1));
    end
  endtask

  always @(posedge clk) en_prev <= clk_en;

  // Monitor: every valid pulse must follow a qualified edge and match the next expectation.
  always @(negedge clk) begin
    if (period_valid === 1'b1) begin
      chk("valid_after_qualified_edge", {31'b0, en_prev}, 1);
      chk("sb_has_entry", {31'b0, (sb.size() != 0)}, 1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("period", {28'b0, period}, {28'b0, e.p});
        chk("locked_at_valid", {31'b0, locked}, {31'b0, e.lk});
        chk("overflow_at_valid", {31'b0, overflow}, {31'b0, e.ov});
      end
    end
  end

  initial begin
    reset   = 1'b1;
    clear   = 1'b0;
    clk_en  = 1'b0;
    tick_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_period", {28'b0, period}, 0);
    chk("rst_valid", {31'b0, period_valid}, 0);
    chk("rst_locked", {31'b0, locked}, 0);
    chk("rst_overflow", {31'b0, overflow}, 0);
    reset = 1'b0;

    // Spacing 5: first tick only syncs, lock on the third tick.
    cyc(1'b1, 1'b1);
    push(5, 1'b0, 1'b0); gap_tick(5);
    push(5, 1'b1, 1'b0); gap_tick(5);
    push(5, 1'b1, 1'b0); gap_tick(5);

    // Change to 7: drops lock, relocks after two 7s.
    push(7, 1'b0, 1'b0); gap_tick(7);
    chk("unlock_on_change", {31'b0, locked}, 0);
    push(7, 1'b1, 1'b0); gap_tick(7);
    push(5, 1'b0, 1'b0); gap_tick(5);
    push(5, 1'b1, 1'b0); gap_tick(5);

    // Clear mid-measurement keeps period, drops lock/overflow.
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    clear = 1'b1;
    cyc(1'b1, 1'b0);
    clear = 1'b0;
    chk("clr_locked", {31'b0, locked}, 0);
    chk("clr_overflow", {31'b0, overflow}, 0);
    chk("clr_period_held", {28'b0, period}, 5);
    cyc(1'b1, 1'b1);
    push(3, 1'b0, 1'b0); gap_tick(3);

    // clk_en every other cycle: period counts qualified cycles only.
    push(4, 1'b0, 1'b0); gap_tick_alt(4);
    push(4, 1'b1, 1'b0); gap_tick_alt(4);

    // Tick coincident with counter at max is a valid period.
    push(15, 1'b0, 1'b0); gap_tick(15);
    push(15, 1'b1, 1'b0); gap_tick(15);
    chk("max_period_no_ovf", {31'b0, overflow}, 0);

    // No tick: overflow on the 15th idle qualified cycle.
    for (int i = 0; i < 14; i++) cyc(1'b1, 1'b0);
    chk("ovf_before_sat", {31'b0, overflow}, 0);
    cyc(1'b1, 1'b0);
    chk("ovf_set", {31'b0, overflow}, 1);
    chk("ovf_unlocks", {31'b0, locked}, 0);
    chk("ovf_period_held", {28'b0, period}, 15);
    cyc(1'b1, 1'b1);
    push(3, 1'b0, 1'b1); gap_tick(3);
    clear = 1'b1;
    cyc(1'b1, 1'b0);
    clear = 1'b0;
    chk("clr_ovf", {31'b0, overflow}, 0);
    chk("clr_period_3", {28'b0, period}, 3);

    // tick_in held high: period 1 every cycle from the second tick.
    cyc(1'b1, 1'b1);
    push(1, 1'b0, 1'b0); cyc(1'b1, 1'b1);
    push(1, 1'b1, 1'b0); cyc(1'b1, 1'b1);
    push(1, 1'b1, 1'b0); cyc(1'b1, 1'b1);
    push(1, 1'b1, 1'b0); cyc(1'b1, 1'b1);
    reset = 1'b1;
    cyc(1'b1, 1'b1);
    chk("rst2_period", {28'b0, period}, 0);
    chk("rst2_valid", {31'b0, period_valid}, 0);
    chk("rst2_locked", {31'b0, locked}, 0);
    chk("rst2_overflow", {31'b0, overflow}, 0);
    reset = 1'b0;

    repeat (4) cyc(1'b0, 1'b0);
    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
